// File: rtl/io_bridge_if.sv
// CPU-side request/response and peripheral-side strobe/data signals of the I/O bridge.
interface io_bridge_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_busy;
  logic [7:0]  io_addr;
  logic [7:0]  io_din;
  logic [3:0]  io_w_en;
  logic [3:0]  io_r_en;
  logic [31:0] io_dout_bus;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, io_dout_bus,
    input  cpu_rdata, cpu_ack, cpu_busy, io_addr, io_din, io_w_en, io_r_en
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, io_dout_bus,
    output cpu_rdata, cpu_ack, cpu_busy, io_addr, io_din, io_w_en, io_r_en
  );
endinterface

// File: rtl/io_bridge.sv
// Turns one CPU I/O request into a single-cycle slot strobe, waits out the
// peripheral read latency and returns read data with a one-cycle acknowledge.
module io_bridge #(
  parameter int unsigned READ_LATENCY  = 1,
  parameter logic [3:0]  SLOT_MASK     = 4'b0001,
  parameter logic [7:0]  UNMAPPED_DATA = 8'hFF
) (
  input logic         clk,
  input logic         rst,
  io_bridge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t     state;
  state_t     state_nxt;
  logic       we_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic [2:0] cnt;

  logic [1:0] slot;
  logic       mapped;
  logic [3:0] slot_hot;
  logic [3:0] w_en;
  logic [3:0] r_en;
  logic       ack;
  logic       busy;

  assign slot     = addr_q[7:6];
  assign mapped   = SLOT_MASK[slot];
  assign slot_hot = 4'b0001 << slot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Strobes and ack decode from the registered state so a reset clears them at once.
  always_comb begin
    state_nxt = state;
    w_en      = 4'b0000;
    r_en      = 4'b0000;
    ack       = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.cpu_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (mapped) begin
          if (we_q) w_en = slot_hot;
          else      r_en = slot_hot;
        end
        state_nxt = (mapped && !we_q) ? WAIT : ACK;
      end
      WAIT: begin
        if (cnt == 3'd1) state_nxt = ACK;
      end
      ACK: begin
        ack       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      cnt     <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            we_q    <= bus.cpu_we;
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
          end
        end
        ISSUE: begin
          if (!we_q) begin
            if (mapped) cnt     <= LAT;
            else        rdata_q <= UNMAPPED_DATA;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          // The last wait cycle is exactly when the peripheral's registered data is valid.
          if (cnt == 3'd1) rdata_q <= bus.io_dout_bus[{slot, 3'b000} +: 8];
        end
        default: ;
      endcase
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_ack   = ack;
  assign bus.cpu_busy  = busy;
  assign bus.io_addr   = {2'b00, addr_q[5:0]};
  assign bus.io_din    = wdata_q;
  assign bus.io_w_en   = w_en;
  assign bus.io_r_en   = r_en;

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: two instances (default parameters and a
// slower, wider-mapped variant) driven by directed and random transactions.
module tb_io_bridge;

  localparam int         LAT_A   = 1;
  localparam int         LAT_B   = 3;
  localparam logic [3:0] MASK_A  = 4'b0001;
  localparam logic [3:0] MASK_B  = 4'b0011;
  localparam logic [7:0] UNMAP_A = 8'hFF;
  localparam logic [7:0] UNMAP_B = 8'hE7;

  typedef struct packed {
    logic [9:0]  ctl;
    logic [7:0]  rdata;
    logic [15:0] addr_din;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   tests_run = 0;
  int   failed    = 0;

  always #5 clk = ~clk;

  io_bridge_if if_a ();
  io_bridge_if if_b ();

  io_bridge #(.READ_LATENCY(LAT_A), .SLOT_MASK(MASK_A), .UNMAPPED_DATA(UNMAP_A))
    u_a (.clk(clk), .rst(rst_a), .bus(if_a));
  io_bridge #(.READ_LATENCY(LAT_B), .SLOT_MASK(MASK_B), .UNMAPPED_DATA(UNMAP_B))
    u_b (.clk(clk), .rst(rst_b), .bus(if_b));

  // Peripheral model: slot data is valid only in the cycle READ_LATENCY after its strobe.
  logic [7:0] periph_a [4] = '{default: 8'h00};
  logic [7:0] periph_b [4] = '{default: 8'h00};
  logic [3:0] pipe_a [8] = '{default: 4'b0000};
  logic [3:0] pipe_b [8] = '{default: 4'b0000};

  always @(posedge clk) begin
    for (int i = 7; i > 0; i--) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
    pipe_a[0] <= if_a.io_r_en;
    pipe_b[0] <= if_b.io_r_en;
  end

  always_comb begin
    if_a.io_dout_bus = 32'h0;
    if_b.io_dout_bus = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if_a.io_dout_bus[8*k +: 8] = pipe_a[LAT_A-1][k] ? periph_a[k] : ~periph_a[k];
      if_b.io_dout_bus[8*k +: 8] = pipe_b[LAT_B-1][k] ? periph_b[k] : ~periph_b[k];
    end
  end

  logic [7:0] exp_rdata [2];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int d, input logic req, input logic we,
                               input logic [7:0] addr, input logic [7:0] wdata);
    if (d == 0) begin
      if_a.cpu_req = req; if_a.cpu_we = we; if_a.cpu_addr = addr; if_a.cpu_wdata = wdata;
    end else begin
      if_b.cpu_req = req; if_b.cpu_we = we; if_b.cpu_addr = addr; if_b.cpu_wdata = wdata;
    end
  endtask

  function automatic obs_t sample(input int d);
    obs_t o;
    if (d == 0) begin
      o.ctl      = {if_a.cpu_ack, if_a.cpu_busy, if_a.io_w_en, if_a.io_r_en};
      o.rdata    = if_a.cpu_rdata;
      o.addr_din = {if_a.io_addr, if_a.io_din};
    end else begin
      o.ctl      = {if_b.cpu_ack, if_b.cpu_busy, if_b.io_w_en, if_b.io_r_en};
      o.rdata    = if_b.cpu_rdata;
      o.addr_din = {if_b.io_addr, if_b.io_din};
    end
    return o;
  endfunction

  // One whole transaction, starting at a negedge with the DUT idle; checks every cycle
  // through the first idle cycle after the ack. With noise, cpu_req stays high with
  // random contents until the ack cycle and must be ignored.
  task automatic runTxn(input int d, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] pval,
                        input bit noise, input string tag);
    int         lat;
    logic [3:0] mask;
    logic [7:0] unmap;
    logic [1:0] slot;
    logic       mapped;
    int         ack_cyc;
    logic [3:0] stb;
    logic [7:0] old_rdata;
    logic [7:0] new_rdata;
    logic [9:0] e_ctl;
    obs_t       o;
    lat    = (d == 0) ? LAT_A : LAT_B;
    mask   = (d == 0) ? MASK_A : MASK_B;
    unmap  = (d == 0) ? UNMAP_A : UNMAP_B;
    slot   = addr[7:6];
    mapped = mask[slot];
    ack_cyc = (mapped && !we) ? 2 + lat : 2;
    stb    = mapped ? (4'b0001 << slot) : 4'b0000;
    old_rdata = exp_rdata[d];
    new_rdata = we ? old_rdata : (mapped ? pval : unmap);
    if (d == 0) periph_a[slot] = pval;
    else        periph_b[slot] = pval;
    applyStimulus(d, 1'b1, we, addr, wdata);
    for (int c = 1; c <= ack_cyc + 1; c++) begin
      @(negedge clk);
      if (noise && c < ack_cyc) applyStimulus(d, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
      else                      applyStimulus(d, 1'b0, 1'b0, 8'h00, 8'h00);
      o = sample(d);
      e_ctl = {(c == ack_cyc) ? 1'b1 : 1'b0,
               (c <= ack_cyc) ? 1'b1 : 1'b0,
               (c == 1 && we)  ? stb : 4'b0000,
               (c == 1 && !we) ? stb : 4'b0000};
      checkOutput($sformatf("%s ctl c%0d", tag, c), 32'(o.ctl), 32'(e_ctl));
      checkOutput($sformatf("%s rdata c%0d", tag, c), 32'(o.rdata),
                  32'((c >= ack_cyc) ? new_rdata : old_rdata));
      checkOutput($sformatf("%s addr_din c%0d", tag, c), 32'(o.addr_din),
                  32'({2'b00, addr[5:0], wdata}));
    end
    exp_rdata[d] = new_rdata;
  endtask

  initial begin
    obs_t o;
    int   acks;
    int   ack_map;
    int   wpulses;
    int   guard;
    rst_a = 1'b1;
    rst_b = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = sample(d);
      checkOutput($sformatf("reset ctl d%0d", d), 32'(o.ctl), 32'h0);
      checkOutput($sformatf("reset rdata d%0d", d), 32'(o.rdata), 32'h0);
      checkOutput($sformatf("reset addr_din d%0d", d), 32'(o.addr_din), 32'h0);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    runTxn(0, 1'b1, 8'h01, 8'hA5, 8'h00, 1'b0, "wr01");
    runTxn(0, 1'b0, 8'h02, 8'h00, 8'h3C, 1'b0, "rd02");
    runTxn(0, 1'b0, 8'h80, 8'h00, 8'h00, 1'b0, "rd80_unmapped");
    runTxn(0, 1'b1, 8'hC0, 8'h5E, 8'h00, 1'b0, "wrC0_unmapped");
    runTxn(1, 1'b0, 8'h45, 8'h00, 8'h5A, 1'b1, "rd45_lat3_noise");

    // Reset while waiting for read data: everything drops without a clock edge.
    applyStimulus(1, 1'b1, 1'b0, 8'h41, 8'h00);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    o = sample(1);
    checkOutput("pre_reset busy", 32'(o.ctl[8]), 32'h1);
    #2 rst_b = 1'b1;
    #1 o = sample(1);
    checkOutput("async_reset ctl", 32'(o.ctl), 32'h0);
    checkOutput("async_reset rdata", 32'(o.rdata), 32'h0);
    exp_rdata[1] = 8'h00;
    @(negedge clk);
    rst_b = 1'b0;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      o = sample(1);
      if (o.ctl[9] || o.ctl[8]) acks++;
    end
    checkOutput("post_reset quiet", 32'(acks), 32'h0);
    runTxn(1, 1'b1, 8'h42, 8'h77, 8'h00, 1'b0, "post_reset_wr");

    // cpu_req held high for cycles 0..9 of back-to-back writes.
    acks = 0; ack_map = 0; wpulses = 0;
    applyStimulus(0, 1'b1, 1'b1, 8'h03, 8'h11);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      o = sample(0);
      if (o.ctl[9]) begin acks++; ack_map |= (1 << c); end
      if (o.ctl[7:4] != 4'b0000) wpulses++;
    end
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("held_req ack count", 32'(acks), 32'd3);
    checkOutput("held_req ack cycles", 32'(ack_map), 32'h124);
    checkOutput("held_req strobes", 32'(wpulses), 32'd3);
    guard = 0;
    while (sample(0).ctl[8] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("held_req drained", 32'(sample(0).ctl[8]), 32'h0);

    for (int i = 0; i < 40; i++) begin
      runTxn(int'($urandom_range(0, 1)), 1'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/io_bridge.md
# io_bridge

Bridge between the CPU core's I/O port and the memory-mapped peripherals (GPIO, timers, UART). It turns one CPU I/O request into a single-cycle `w_en`/`r_en` strobe for the selected peripheral slot. It waits out the peripheral's registered read latency and returns read data to the core with a one-cycle acknowledge. The 8-bit I/O space is split into four 64-byte slots, selected by `cpu_addr[7:6]`.

## Interface

Parameters:
- `READ_LATENCY`, default 1: cycles from `io_r_en` to valid peripheral `dout`. Legal range 1..7.
- `SLOT_MASK`, default 4'b0001: bit k set means slot k is populated.
- `UNMAPPED_DATA`, default 8'hFF: read data returned for an unpopulated slot.

Ports:
- `clk`  in  1: the single clock; everything is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `cpu_req`  in  1: request strobe, sampled only in IDLE.
- `cpu_we`  in  1: 1 = write, 0 = read.
- `cpu_addr`  in  8: I/O address.
- `cpu_wdata`  in  8: write data.
- `cpu_rdata`  out  8: read data; valid while `cpu_ack`=1 and held until the next read completes.
- `cpu_ack`  out  1: one-cycle completion pulse.
- `cpu_busy`  out  1: high whenever state ≠ IDLE.
- `io_addr`  out  8: local address `{2'b00, addr[5:0]}` for the peripheral.
- `io_din`  out  8: write data to the peripheral.
- `io_w_en`  out  4: one-hot write strobe per slot.
- `io_r_en`  out  4: one-hot read strobe per slot.
- `io_dout_bus`  in  32: peripheral read data; slot k occupies bits [8k+7:8k].

## Operation

- States: IDLE, ISSUE, WAIT, ACK. The state is registered; strobes and `cpu_ack` are decoded from the registered state.
- IDLE:
  - On `cpu_req`=1, latch `cpu_we`, `cpu_addr` and `cpu_wdata`, then go to ISSUE.
  - The slot is `addr[7:6]`.
  - `cpu_req` is ignored in every other state; no queueing.
- ISSUE (always one cycle):
  - If the slot is populated, assert exactly one bit (`io_w_en[slot]` or `io_r_en[slot]`) for this cycle only.
  - Next state:
    - Mapped read: load the wait counter with `READ_LATENCY`, go to WAIT.
    - Write: go to ACK.
    - Unmapped read or write: go to ACK.
  - An unmapped write produces no strobe. An unmapped read loads `UNMAPPED_DATA` into the rdata register.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter equals 1, capture `io_dout_bus[8*slot+7 -: 8]` into the rdata register and go to ACK.
- ACK: `cpu_ack`=1 for one cycle, then go to IDLE.
- `io_addr` and `io_din` come from the latched values and stay stable from ISSUE through ACK.
- `cpu_rdata` is unchanged by writes.

## Timing

Cycle 0 is the cycle in which IDLE samples `cpu_req`.
- Write: strobe in cycle 1, ack in cycle 2. Next request is accepted in cycle 3.
- Mapped read: strobe in cycle 1, WAIT in cycles 2..1+`READ_LATENCY`, ack in cycle 2+`READ_LATENCY` (cycle 3 at the default).
- Unmapped access: ack in cycle 2.
- Throughput: one transaction per 3 cycles for writes, 3+`READ_LATENCY` for reads.
- Reset values:
  - state = IDLE.
  - `cpu_ack`, `cpu_busy`, `io_w_en`, `io_r_en` = 0.
  - `cpu_rdata`, `io_addr`, `io_din` = 0.
  - Wait counter = 0.
- Reset mid-transaction:
  - Outputs drop immediately (asynchronous), with no ack for the aborted transaction.
  - The first request after reset release is processed normally.
- `cpu_req` held high continuously: one transaction per pass through IDLE; requests are never issued back-to-back without an IDLE cycle.

## Test plan

- Write 0xA5 to 0x01: `io_w_en`=0001 for exactly cycle 1, `io_addr`=0x01, `io_din`=0xA5; `cpu_ack` in cycle 2; `io_r_en` stays 0.
- Read 0x02 with slot 0 driving `io_dout_bus[7:0]`=0x3C one cycle after `io_r_en`: `io_r_en`=0001 in cycle 1; ack in cycle 3 with `cpu_rdata`=0x3C.
- Read 0x80 with `SLOT_MASK`=0001: no strobe; ack in cycle 2 with `cpu_rdata`=0xFF. Write 0xC0: no strobe; ack in cycle 2.
- `READ_LATENCY`=3, read 0x45 with `SLOT_MASK`=0011: `io_r_en`=0010, `io_addr`=0x05; data captured from bits [15:8] with ack in cycle 5. A `cpu_req` pulse in cycles 1–4 is ignored.
- Assert `rst` during WAIT: `cpu_busy`, all strobes and `cpu_ack` go to 0 asynchronously; no ack follows. A subsequent write completes in 3 cycles.
- Hold `cpu_req`=1 for 10 cycles of writes: exactly 3 acks, in cycles 2, 5 and 8.
